// File: rtl/serial_link_pkg.sv
// Shared types and constants for the serial link stages.
package serial_link_pkg;

    // Transmitter frame phases.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Level the line rests at between frames; stop bits use it as well.
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: emits a one-cycle bit_tick_o on the last clock of each
// BIT_CYCLES-long bit period while running.
module tx_bit_timer #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic run_i,
    output logic bit_tick_o
);

    localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCycle = CntW'(BIT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Tick is decoded from the registered count so it lines up with the bit's last cycle.
    assign bit_tick_o = run_i && (cnt_q == LastCycle);

    // Next count: clear on accept, otherwise count and wrap at each bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = bit_tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits MSB-first, STOP_BITS
// stop bits, each held for BIT_CYCLES clocks on a registered s_out.
module serial_frame_tx
    import serial_link_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BitCntW = $clog2(WIDTH + 1);
    localparam logic [BitCntW-1:0] LastDataBit = BitCntW'(WIDTH - 1);
    localparam logic [BitCntW-1:0] LastStopBit = BitCntW'(STOP_BITS - 1);

    tx_state_t          state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
    logic               s_out_q, s_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;
    logic               bit_tick;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;
    assign s_out    = s_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

    tx_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (accept),
        .run_i      (busy_q),
        .bit_tick_o (bit_tick)
    );

    // Next-state and next-output decode; outputs are computed for the state being entered.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        s_out_d   = s_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
                    s_out_d   = ~LINE_IDLE;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    s_out_d = shreg_q[WIDTH-1];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    if (bit_cnt_q == LastDataBit) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                        s_out_d   = LINE_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        // Next MSB is the bit just below the one being shifted out.
                        s_out_d   = shreg_q[WIDTH-2];
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    // Bit counter is reused to count stop bits.
                    if (bit_cnt_q == LastStopBit) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_out_d = LINE_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            s_out_q   <= LINE_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            s_out_q   <= s_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: default instance plus a stretched-bit,
// two-stop-bit instance. Inputs change and outputs are sampled on the falling edge.
module tb_serial_frame_tx;

    logic       clk;
    logic       rst_n;

    logic       a_valid;
    logic [3:0] a_data;
    logic       a_ready, a_sout, a_busy, a_done;

    logic       b_valid;
    logic [3:0] b_data;
    logic       b_ready, b_sout, b_busy, b_done;

    int n_cmp;
    int n_err;

    serial_frame_tx u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (a_valid),
        .in_data  (a_data),
        .in_ready (a_ready),
        .s_out    (a_sout),
        .busy     (a_busy),
        .done     (a_done)
    );

    serial_frame_tx #(
        .WIDTH      (4),
        .STOP_BITS  (2),
        .BIT_CYCLES (3)
    ) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (b_valid),
        .in_data  (b_data),
        .in_ready (b_ready),
        .s_out    (b_sout),
        .busy     (b_busy),
        .done     (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n   = 1'b0;
        a_valid = 1'b0;
        a_data  = 4'h0;
        b_valid = 1'b0;
        b_data  = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_sout, a_busy, a_done, a_ready} !== 4'b1001) begin
            n_err++;
            $display("FAIL reset_a {sout,busy,done,ready} got %b want 1001",
                     {a_sout, a_busy, a_done, a_ready});
        end
        n_cmp++;
        if ({b_sout, b_busy, b_done, b_ready} !== 4'b1001) begin
            n_err++;
            $display("FAIL reset_b {sout,busy,done,ready} got %b want 1001",
                     {b_sout, b_busy, b_done, b_ready});
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (a_sout !== 1'b1) begin
                n_err++;
                $display("FAIL idle_sout cycle %0d got %b want 1", c, a_sout);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [5:0] exp_s;
        exp_s = 6'b011011;  // start, 1101, stop
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = 4'b1101;
        @(negedge clk);     // cycle 1
        a_valid = 1'b0;
        a_data  = 4'h0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            n_cmp++;
            if (a_sout !== exp_s[6-c]) begin
                n_err++;
                $display("FAIL single_sout cycle %0d got %b want %b", c, a_sout, exp_s[6-c]);
            end
            n_cmp++;
            if ({a_busy, a_done, a_ready} !== 3'b100) begin
                n_err++;
                $display("FAIL single_flags cycle %0d {busy,done,ready} got %b want 100",
                         c, {a_busy, a_done, a_ready});
            end
        end
        @(negedge clk);     // cycle 7
        n_cmp++;
        if ({a_sout, a_busy, a_done, a_ready} !== 4'b1011) begin
            n_err++;
            $display("FAIL single_done {sout,busy,done,ready} got %b want 1011",
                     {a_sout, a_busy, a_done, a_ready});
        end
        @(negedge clk);     // cycle 8
        n_cmp++;
        if ({a_done, a_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL single_done_pulse {done,ready} got %b want 01", {a_done, a_ready});
        end
    endtask

    task automatic test_stretched();
        logic [6:0] exp_b;
        int         busy_cnt;
        int         idx;
        exp_b    = 7'b0100111;  // start, 1001, stop, stop
        busy_cnt = 0;
        @(negedge clk);
        b_valid = 1'b1;
        b_data  = 4'b1001;
        @(negedge clk);     // cycle 1
        b_valid = 1'b0;
        b_data  = 4'h0;
        for (int c = 1; c <= 21; c++) begin
            if (c > 1) @(negedge clk);
            idx = (c - 1) / 3;
            if (b_busy === 1'b1) busy_cnt++;
            n_cmp++;
            if (b_sout !== exp_b[6-idx]) begin
                n_err++;
                $display("FAIL stretch_sout cycle %0d got %b want %b", c, b_sout, exp_b[6-idx]);
            end
            n_cmp++;
            if (b_done !== 1'b0) begin
                n_err++;
                $display("FAIL stretch_early_done cycle %0d got %b want 0", c, b_done);
            end
        end
        @(negedge clk);     // cycle 22
        n_cmp++;
        if (busy_cnt != 21) begin
            n_err++;
            $display("FAIL stretch_busy_len got %0d want 21", busy_cnt);
        end
        n_cmp++;
        if ({b_sout, b_busy, b_done, b_ready} !== 4'b1011) begin
            n_err++;
            $display("FAIL stretch_done {sout,busy,done,ready} got %b want 1011",
                     {b_sout, b_busy, b_done, b_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_1;
        logic [5:0] exp_2;
        exp_1 = 6'b010101;  // start, 1010, stop
        exp_2 = 6'b001101;  // start, 0110, stop
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = 4'b1010;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 2) a_data = 4'b1111;  // mid-frame change must be ignored
            n_cmp++;
            if (a_sout !== exp_1[6-c] || a_ready !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_first cycle %0d {sout,ready} got %b%b want %b0",
                         c, a_sout, a_ready, exp_1[6-c]);
            end
        end
        @(negedge clk);     // cycle 7
        n_cmp++;
        if ({a_done, a_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL b2b_done {done,ready} got %b want 11", {a_done, a_ready});
        end
        a_data = 4'b0110;   // accepted on this done cycle
        for (int c = 8; c <= 13; c++) begin
            @(negedge clk);
            if (c == 8) a_valid = 1'b0;
            n_cmp++;
            if (a_sout !== exp_2[13-c] || a_busy !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_second cycle %0d {sout,busy} got %b%b want %b1",
                         c, a_sout, a_busy, exp_2[13-c]);
            end
        end
        @(negedge clk);     // cycle 14
        n_cmp++;
        if ({a_busy, a_done, a_ready} !== 3'b011) begin
            n_err++;
            $display("FAIL b2b_second_done {busy,done,ready} got %b want 011",
                     {a_busy, a_done, a_ready});
        end
        @(negedge clk);
        n_cmp++;
        if ({a_busy, a_done} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_no_third {busy,done} got %b want 00", {a_busy, a_done});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [5:0] exp_s;
        exp_s = 6'b000111;  // start, 0011, stop
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = 4'b1100;
        @(negedge clk);     // cycle 1
        a_valid = 1'b0;
        repeat (3) @(negedge clk);  // cycle 4: data bit 2
        n_cmp++;
        if ({a_sout, a_busy} !== 2'b01) begin
            n_err++;
            $display("FAIL mid_before_reset {sout,busy} got %b want 01", {a_sout, a_busy});
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({a_sout, a_busy, a_done, a_ready} !== 4'b1001) begin
            n_err++;
            $display("FAIL mid_after_reset {sout,busy,done,ready} got %b want 1001",
                     {a_sout, a_busy, a_done, a_ready});
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_sout, a_done} !== 2'b10) begin
                n_err++;
                $display("FAIL mid_no_done cycle %0d {sout,done} got %b want 10",
                         c, {a_sout, a_done});
            end
        end
        a_valid = 1'b1;
        a_data  = 4'b0011;
        @(negedge clk);     // cycle 1
        a_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            n_cmp++;
            if (a_sout !== exp_s[6-c]) begin
                n_err++;
                $display("FAIL mid_clean_sout cycle %0d got %b want %b", c, a_sout, exp_s[6-c]);
            end
        end
        @(negedge clk);     // cycle 7
        n_cmp++;
        if ({a_busy, a_done, a_ready} !== 3'b011) begin
            n_err++;
            $display("FAIL mid_clean_done {busy,done,ready} got %b want 011",
                     {a_busy, a_done, a_ready});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_frame();
        test_stretched();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
